// File: rtl/bp_cfg_seq_loader.sv
// Walks every (core, register) pair of a config table, issuing one write beat per pair
// over a valid/ready request port, optionally reading each register back and comparing it.
`timescale 1ns/1ps
module bp_cfg_seq_loader #(
    parameter int num_core_p       = 4,
    parameter int num_regs_p       = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int readback_p       = 0,
    localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1,
    localparam int reg_w_lp  = (num_regs_p > 1) ? $clog2(num_regs_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   start_i,
    input  logic [num_regs_p*cfg_addr_width_p-1:0] reg_addr_i,
    input  logic [num_regs_p*cfg_data_width_p-1:0] reg_data_i,
    input  logic                                   cfg_ready_i,
    output logic                                   cfg_v_o,
    output logic                                   cfg_w_o,
    output logic [core_w_lp-1:0]                   cfg_core_id_o,
    output logic [cfg_addr_width_p-1:0]            cfg_addr_o,
    output logic [cfg_data_width_p-1:0]            cfg_data_o,
    input  logic                                   resp_v_i,
    input  logic [cfg_data_width_p-1:0]            resp_data_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   error_o,
    output logic [core_w_lp-1:0]                   err_core_o,
    output logic [reg_w_lp-1:0]                    err_reg_o
);

    localparam logic [core_w_lp-1:0] last_core_lp = core_w_lp'(num_core_p - 1);
    localparam logic [reg_w_lp-1:0]  last_reg_lp  = reg_w_lp'(num_regs_p - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ_W     = 3'd1,
        REQ_R     = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4
    } state_e;

    state_e                state_r, state_s, adv_state_s;
    logic [core_w_lp-1:0]  core_r, core_s, adv_core_s;
    logic [reg_w_lp-1:0]   reg_r, reg_s, adv_reg_s;
    logic                  error_r, error_s;
    logic [core_w_lp-1:0]  err_core_r, err_core_s;
    logic [reg_w_lp-1:0]   err_reg_r, err_reg_s;

    logic                        cfg_v_r, cfg_w_r, busy_r, done_r;
    logic                        cfg_v_s, cfg_w_s, busy_s, done_s;
    logic [core_w_lp-1:0]        cfg_core_r, cfg_core_s;
    logic [cfg_addr_width_p-1:0] cfg_addr_r, cfg_addr_s;
    logic [cfg_data_width_p-1:0] cfg_data_r, cfg_data_s;

    function automatic logic [cfg_addr_width_p-1:0] pick_addr(input logic [reg_w_lp-1:0] idx);
        logic [cfg_addr_width_p-1:0] val;
        val = '0;
        for (int i = 0; i < num_regs_p; i++) begin
            val |= (idx == reg_w_lp'(i)) ? reg_addr_i[i*cfg_addr_width_p +: cfg_addr_width_p] : '0;
        end
        return val;
    endfunction

    function automatic logic [cfg_data_width_p-1:0] pick_data(input logic [reg_w_lp-1:0] idx);
        logic [cfg_data_width_p-1:0] val;
        val = '0;
        for (int i = 0; i < num_regs_p; i++) begin
            val |= (idx == reg_w_lp'(i)) ? reg_data_i[i*cfg_data_width_p +: cfg_data_width_p] : '0;
        end
        return val;
    endfunction

    // Position after the current register completes: next reg, next core, or finished
    always_comb begin
        adv_state_s = REQ_W;
        adv_core_s  = core_r;
        adv_reg_s   = reg_r;
        if (reg_r == last_reg_lp) begin
            adv_reg_s = '0;
            if (core_r == last_core_lp) begin
                adv_state_s = DONE;
            end else begin
                adv_core_s = core_r + 1'b1;
            end
        end else begin
            adv_reg_s = reg_r + 1'b1;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_s    = state_r;
        core_s     = core_r;
        reg_s      = reg_r;
        error_s    = error_r;
        err_core_s = err_core_r;
        err_reg_s  = err_reg_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    state_s    = REQ_W;
                    core_s     = '0;
                    reg_s      = '0;
                    error_s    = 1'b0;
                    err_core_s = '0;
                    err_reg_s  = '0;
                end else begin
                    state_s = state_r;
                end
            end
            REQ_W: begin
                if (cfg_ready_i) begin
                    if (readback_p != 0) begin
                        state_s = REQ_R;
                    end else begin
                        state_s = adv_state_s;
                        core_s  = adv_core_s;
                        reg_s   = adv_reg_s;
                    end
                end else begin
                    state_s = REQ_W;
                end
            end
            REQ_R: begin
                if (cfg_ready_i) begin
                    state_s = WAIT_RESP;
                end else begin
                    state_s = REQ_R;
                end
            end
            WAIT_RESP: begin
                if (!resp_v_i) begin
                    state_s = WAIT_RESP;
                end else if (resp_data_i == pick_data(reg_r)) begin
                    state_s = adv_state_s;
                    core_s  = adv_core_s;
                    reg_s   = adv_reg_s;
                end else begin
                    state_s    = DONE;
                    error_s    = 1'b1;
                    err_core_s = core_r;
                    err_reg_s  = reg_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port leaves a flop
    always_comb begin
        cfg_v_s    = (state_s == REQ_W) || (state_s == REQ_R);
        cfg_w_s    = (state_s == REQ_W);
        busy_s     = cfg_v_s || (state_s == WAIT_RESP);
        done_s     = (state_s == DONE);
        cfg_core_s = '0;
        cfg_addr_s = '0;
        cfg_data_s = '0;
        if (cfg_v_s) begin
            cfg_core_s = core_s;
            cfg_addr_s = pick_addr(reg_s);
        end else begin
            cfg_core_s = '0;
        end
        if (cfg_w_s) begin
            cfg_data_s = pick_data(reg_s);
        end else begin
            cfg_data_s = '0;
        end
    end

    // State, counters, error capture and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            core_r     <= '0;
            reg_r      <= '0;
            error_r    <= 1'b0;
            err_core_r <= '0;
            err_reg_r  <= '0;
            cfg_v_r    <= 1'b0;
            cfg_w_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cfg_core_r <= '0;
            cfg_addr_r <= '0;
            cfg_data_r <= '0;
        end else begin
            state_r    <= state_s;
            core_r     <= core_s;
            reg_r      <= reg_s;
            error_r    <= error_s;
            err_core_r <= err_core_s;
            err_reg_r  <= err_reg_s;
            cfg_v_r    <= cfg_v_s;
            cfg_w_r    <= cfg_w_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            cfg_core_r <= cfg_core_s;
            cfg_addr_r <= cfg_addr_s;
            cfg_data_r <= cfg_data_s;
        end
    end

    assign cfg_v_o       = cfg_v_r;
    assign cfg_w_o       = cfg_w_r;
    assign cfg_core_id_o = cfg_core_r;
    assign cfg_addr_o    = cfg_addr_r;
    assign cfg_data_o    = cfg_data_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign error_o       = error_r;
    assign err_core_o    = err_core_r;
    assign err_reg_o     = err_reg_r;

endmodule
